sysbus_arb: RTL and testbench

Arbiter for the MERA-400 system bus. It shares the bus between up to N_REQ masters, such as CPUs and channel/DMA controllers, using the zg (request) / zw (grant) / zz_ (release) handshake. The CPU drives zg, samples zw and drives zz_ toward this block. The block also runs a per-grant watchdog on the bus response lines (rok_, ren_, rpe_), so a hung master cannot hold the bus forever.

---
 rtl/sysbus_arb_if.sv | 29 ++
 rtl/sysbus_arb.sv | 121 ++++++++++++
 tb/tb_sysbus_arb.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sysbus_arb_if.sv
// MERA-400 system bus arbitration signals: requests, releases and grants per
// master, bus response lines for the watchdog, and arbiter status.
interface sysbus_arb_if #(
    parameter int N_REQ = 4,
    parameter int OW    = 2
);
    logic [0:N_REQ-1] zg;
    logic [0:N_REQ-1] zz_;
    logic             rok_;
    logic             ren_;
    logic             rpe_;
    logic [0:N_REQ-1] zw;
    logic             busy;
    logic [0:OW-1]    owner;
    logic             tmo_;
    logic [0:OW-1]    tmo_owner;

    // Bus masters and responders drive requests and response lines.
    modport master (
        output zg, zz_, rok_, ren_, rpe_,
        input  zw, busy, owner, tmo_, tmo_owner
    );

    // The arbiter samples requests and drives grants and status.
    modport slave (
        input  zg, zz_, rok_, ren_, rpe_,
        output zw, busy, owner, tmo_, tmo_owner
    );
endinterface

// File: rtl/sysbus_arb.sv
// System bus arbiter: fixed-priority or round-robin grant of the bus to one
// master at a time, with a response watchdog that forces release of a hung owner.
module sysbus_arb #(
    parameter int N_REQ   = 4,
    parameter int RR      = 1,
    parameter int TIMEOUT = 255,
    parameter int OW      = 2
) (
    input  logic         __clk,
    input  logic         clm_,
    sysbus_arb_if.slave  bus
);
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t           state_reg;
    logic [0:N_REQ-1] zw_reg;
    logic             busy_reg;
    logic             tmo_n_reg;
    logic [0:OW-1]    owner_reg;
    logic [0:OW-1]    tmo_owner_reg;
    logic [0:OW-1]    rr_ptr_reg;
    logic [WW-1:0]    wd_reg;

    logic [0:OW-1]    start_idx;
    logic [0:OW-1]    scan_idx;
    logic [0:OW-1]    winner;
    logic             found;
    logic [0:N_REQ-1] grant_vec;
    logic             release_req;
    logic             response;

    // Scan the requests once around the ring, starting at the priority pointer.
    always_comb begin
        start_idx = (RR != 0) ? rr_ptr_reg : '0;
        scan_idx  = start_idx;
        found     = 1'b0;
        winner    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && bus.zg[scan_idx]) begin
                found  = 1'b1;
                winner = scan_idx;
            end
            scan_idx = (scan_idx == OW'(N_REQ - 1)) ? '0 : scan_idx + OW'(1);
        end
    end

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_onehot
            assign grant_vec[gi] = (winner == OW'(gi));
        end
    endgenerate

    // Only the owner's request and release bits matter while granted.
    assign release_req = ~bus.zz_[owner_reg] | ~bus.zg[owner_reg];
    assign response    = ~bus.rok_ | ~bus.ren_ | ~bus.rpe_;

    always_ff @(posedge __clk or negedge clm_) begin
        if (!clm_) begin
            state_reg     <= IDLE;
            zw_reg        <= '0;
            busy_reg      <= 1'b0;
            tmo_n_reg     <= 1'b1;
            owner_reg     <= '0;
            tmo_owner_reg <= '0;
            rr_ptr_reg    <= '0;
            wd_reg        <= '0;
        end else begin
            tmo_n_reg <= 1'b1;
            case (state_reg)
                IDLE: begin
                    if (found) begin
                        zw_reg    <= grant_vec;
                        owner_reg <= winner;
                        busy_reg  <= 1'b1;
                        wd_reg    <= '0;
                        state_reg <= GRANT;
                    end
                end
                GRANT: begin
                    // Release beats expiry, and a response beats expiry.
                    if (release_req) begin
                        zw_reg    <= '0;
                        busy_reg  <= 1'b0;
                        state_reg <= GAP;
                    end else if (response) begin
                        wd_reg <= '0;
                    end else if (wd_reg == WW'(TIMEOUT)) begin
                        zw_reg        <= '0;
                        busy_reg      <= 1'b0;
                        tmo_n_reg     <= 1'b0;
                        tmo_owner_reg <= owner_reg;
                        state_reg     <= GAP;
                    end else begin
                        wd_reg <= wd_reg + WW'(1);
                    end
                end
                GAP: begin
                    rr_ptr_reg <= (owner_reg == OW'(N_REQ - 1)) ? '0 : owner_reg + OW'(1);
                    state_reg  <= IDLE;
                end
                default: begin
                    zw_reg    <= '0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.zw        = zw_reg;
    assign bus.busy      = busy_reg;
    assign bus.owner     = owner_reg;
    assign bus.tmo_      = tmo_n_reg;
    assign bus.tmo_owner = tmo_owner_reg;
endmodule

// File: tb/tb_sysbus_arb.sv
// Bench for sysbus_arb: a round-robin and a fixed-priority instance share one
// stimulus stream and are checked every cycle against a rule-level model.
module tb_sysbus_arb;
    localparam int N   = 4;
    localparam int OW  = 2;
    localparam int TMO = 8;

    logic clk = 1'b0;
    logic clm_;
    always #5 clk = ~clk;

    sysbus_arb_if #(.N_REQ(N), .OW(OW)) bus_rr ();
    sysbus_arb_if #(.N_REQ(N), .OW(OW)) bus_fp ();

    sysbus_arb #(.N_REQ(N), .RR(1), .TIMEOUT(TMO), .OW(OW)) u_rr (
        .__clk(clk), .clm_(clm_), .bus(bus_rr)
    );
    sysbus_arb #(.N_REQ(N), .RR(0), .TIMEOUT(TMO), .OW(OW)) u_fp (
        .__clk(clk), .clm_(clm_), .bus(bus_fp)
    );

    // ph: 0 idle, 1 granted, 2 turnaround; wd counts silent granted edges.
    typedef struct {
        int   ph;
        int   own;
        int   wd;
        int   ptr;
        logic tmo;
        int   tmo_own;
    } mdl_t;

    mdl_t m_rr, m_fp;
    int   n_assert = 0;
    int   n_fail   = 0;

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.ph = 0; m.own = 0; m.wd = 0; m.ptr = 0; m.tmo = 1'b1; m.tmo_own = 0;
        return m;
    endfunction

    function automatic mdl_t mdl_step(mdl_t m, logic [0:N-1] g, logic [0:N-1] z,
                                      logic resp, bit rr);
        mdl_t n = m;
        n.tmo = 1'b1;
        if (m.ph == 0) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = rr ? (m.ptr + k) % N : k;
                if (n.ph == 0 && g[c] === 1'b1) begin
                    n.ph = 1; n.own = c; n.wd = 0;
                end
            end
        end else if (m.ph == 1) begin
            if (z[m.own] !== 1'b1 || g[m.own] !== 1'b1) n.ph = 2;
            else if (resp) n.wd = 0;
            else if (m.wd >= TMO) begin
                n.ph = 2; n.tmo = 1'b0; n.tmo_own = m.own;
            end else n.wd = m.wd + 1;
        end else begin
            n.ph  = 0;
            n.ptr = (m.own + 1) % N;
        end
        return n;
    endfunction

    function automatic logic [0:N-1] exp_zw(mdl_t m);
        logic [0:N-1] v;
        v = '0;
        if (m.ph == 1) v[m.own] = 1'b1;
        return v;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("rr.zw",        32'(bus_rr.zw),        32'(exp_zw(m_rr)));
        chk("rr.busy",      32'(bus_rr.busy),      32'(m_rr.ph == 1));
        chk("rr.owner",     32'(bus_rr.owner),     32'(m_rr.own));
        chk("rr.tmo_",      32'(bus_rr.tmo_),      32'(m_rr.tmo));
        chk("rr.tmo_owner", 32'(bus_rr.tmo_owner), 32'(m_rr.tmo_own));
        chk("fp.zw",        32'(bus_fp.zw),        32'(exp_zw(m_fp)));
        chk("fp.busy",      32'(bus_fp.busy),      32'(m_fp.ph == 1));
        chk("fp.owner",     32'(bus_fp.owner),     32'(m_fp.own));
        chk("fp.tmo_",      32'(bus_fp.tmo_),      32'(m_fp.tmo));
        chk("fp.tmo_owner", 32'(bus_fp.tmo_owner), 32'(m_fp.tmo_own));
    endtask

    task automatic cycle(input logic [0:N-1] g, input logic [0:N-1] z,
                         input logic ok, input logic en, input logic pe);
        @(negedge clk);
        bus_rr.zg = g; bus_rr.zz_ = z; bus_rr.rok_ = ok; bus_rr.ren_ = en; bus_rr.rpe_ = pe;
        bus_fp.zg = g; bus_fp.zz_ = z; bus_fp.rok_ = ok; bus_fp.ren_ = en; bus_fp.rpe_ = pe;
        @(posedge clk);
        m_rr = mdl_step(m_rr, g, z, !(ok && en && pe), 1'b1);
        m_fp = mdl_step(m_fp, g, z, !(ok && en && pe), 1'b0);
        #1;
        check_all();
        $display("cyc zg=%b zz_=%b rsp=%b%b%b | rr zw=%b own=%0d tmo_=%b | fp zw=%b own=%0d tmo_=%b",
                 g, z, ok, en, pe, bus_rr.zw, bus_rr.owner, bus_rr.tmo_,
                 bus_fp.zw, bus_fp.owner, bus_fp.tmo_);
    endtask

    logic [0:N-1] g, z, gh;
    logic         ok, en, pe, prev_busy;
    int           mode, hold, fp_wins;
    int           rr_order[$];
    int           exp_order[5] = '{0, 1, 2, 3, 0};

    initial begin
        clm_ = 1'b0;
        bus_rr.zg = '0; bus_rr.zz_ = '1; bus_rr.rok_ = 1'b1; bus_rr.ren_ = 1'b1; bus_rr.rpe_ = 1'b1;
        bus_fp.zg = '0; bus_fp.zz_ = '1; bus_fp.rok_ = 1'b1; bus_fp.ren_ = 1'b1; bus_fp.rpe_ = 1'b1;
        m_rr = mdl_reset();
        m_fp = mdl_reset();
        #6;
        check_all();
        @(negedge clk);
        clm_ = 1'b1;

        // Idle with no requests.
        repeat (10) cycle(4'b0000, 4'b1111, 1'b1, 1'b1, 1'b1);

        // Single grant, one-cycle latency, release via zz_.
        cycle(4'b0010, 4'b1111, 1'b1, 1'b1, 1'b1);
        chk("single.zw", 32'(bus_rr.zw), 32'b0010);
        chk("single.owner", 32'(bus_rr.owner), 2);
        cycle(4'b0010, 4'b1101, 1'b1, 1'b1, 1'b1);
        chk("single.release", 32'(bus_rr.zw), 32'b0000);
        repeat (2) cycle(4'b0000, 4'b1111, 1'b1, 1'b1, 1'b1);

        // Fixed priority: requester 1 keeps winning.
        hold = 0; fp_wins = 0;
        repeat (30) begin
            z = '1;
            if (m_fp.ph == 1 && hold >= 3) z[m_fp.own] = 1'b0;
            prev_busy = bus_fp.busy;
            cycle(4'b0111, z, 1'b1, 1'b1, 1'b1);
            hold = (m_fp.ph == 1) ? hold + 1 : 0;
            if (!prev_busy && bus_fp.busy) begin
                fp_wins++;
                chk("fp.prio", 32'(bus_fp.owner), 1);
            end
        end
        chk("fp.grant_count", 32'(fp_wins >= 4), 1);
        repeat (3) cycle(4'b0000, 4'b1111, 1'b1, 1'b1, 1'b1);

        // Asynchronous reset in the middle of a grant.
        cycle(4'b1111, 4'b1111, 1'b1, 1'b1, 1'b1);
        #3;
        clm_ = 1'b0;
        #1;
        chk("arst.rr.zw", 32'(bus_rr.zw), 0);
        chk("arst.rr.busy", 32'(bus_rr.busy), 0);
        chk("arst.rr.tmo_", 32'(bus_rr.tmo_), 1);
        chk("arst.fp.zw", 32'(bus_fp.zw), 0);
        chk("arst.fp.busy", 32'(bus_fp.busy), 0);
        m_rr = mdl_reset();
        m_fp = mdl_reset();
        @(negedge clk);
        clm_ = 1'b1;

        // Round robin rotation under full request load.
        hold = 0;
        repeat (40) begin
            z = '1;
            if (m_rr.ph == 1 && hold >= 2) z[m_rr.own] = 1'b0;
            prev_busy = bus_rr.busy;
            cycle(4'b1111, z, 1'b1, 1'b1, 1'b1);
            hold = (m_rr.ph == 1) ? hold + 1 : 0;
            if (!prev_busy && bus_rr.busy) rr_order.push_back(int'(bus_rr.owner));
        end
        chk("rr.order_count", 32'(rr_order.size() >= 5), 1);
        for (int k = 0; k < 5; k++)
            if (k < rr_order.size()) chk("rr.order", 32'(rr_order[k]), 32'(exp_order[k]));
        repeat (3) cycle(4'b0000, 4'b1111, 1'b1, 1'b1, 1'b1);

        // Watchdog expiry on the 9th edge after the grant.
        cycle(4'b0001, 4'b1111, 1'b1, 1'b1, 1'b1);
        chk("wd.owner", 32'(bus_rr.owner), 3);
        repeat (TMO) begin
            cycle(4'b0001, 4'b1111, 1'b1, 1'b1, 1'b1);
            chk("wd.held", 32'(bus_rr.busy), 1);
        end
        cycle(4'b0001, 4'b1111, 1'b1, 1'b1, 1'b1);
        chk("wd.expire_busy", 32'(bus_rr.busy), 0);
        chk("wd.expire_tmo_", 32'(bus_rr.tmo_), 0);
        chk("wd.tmo_owner", 32'(bus_rr.tmo_owner), 3);
        cycle(4'b0000, 4'b1111, 1'b1, 1'b1, 1'b1);
        chk("wd.tmo_pulse_end", 32'(bus_rr.tmo_), 1);
        cycle(4'b0000, 4'b1111, 1'b1, 1'b1, 1'b1);

        // A response part way through restarts the count.
        cycle(4'b0001, 4'b1111, 1'b1, 1'b1, 1'b1);
        repeat (5) cycle(4'b0001, 4'b1111, 1'b1, 1'b1, 1'b1);
        cycle(4'b0001, 4'b1111, 1'b0, 1'b1, 1'b1);
        repeat (TMO) begin
            cycle(4'b0001, 4'b1111, 1'b1, 1'b1, 1'b1);
            chk("wd.restart_held", 32'(bus_rr.busy), 1);
        end
        cycle(4'b0001, 4'b1111, 1'b1, 1'b1, 1'b1);
        chk("wd.restart_tmo_", 32'(bus_rr.tmo_), 0);
        repeat (2) cycle(4'b0000, 4'b1111, 1'b1, 1'b1, 1'b1);

        // Release on the expiry edge: no timeout pulse.
        cycle(4'b0001, 4'b1111, 1'b1, 1'b1, 1'b1);
        repeat (TMO) cycle(4'b0001, 4'b1111, 1'b1, 1'b1, 1'b1);
        cycle(4'b0001, 4'b1110, 1'b1, 1'b1, 1'b1);
        chk("sim.rel_busy", 32'(bus_rr.busy), 0);
        chk("sim.rel_tmo_", 32'(bus_rr.tmo_), 1);
        repeat (2) cycle(4'b0000, 4'b1111, 1'b1, 1'b1, 1'b1);

        // Response on the expiry edge: grant kept.
        cycle(4'b0001, 4'b1111, 1'b1, 1'b1, 1'b1);
        repeat (TMO) cycle(4'b0001, 4'b1111, 1'b1, 1'b1, 1'b1);
        cycle(4'b0001, 4'b1111, 1'b0, 1'b1, 1'b1);
        chk("sim.rsp_busy", 32'(bus_rr.busy), 1);
        chk("sim.rsp_tmo_", 32'(bus_rr.tmo_), 1);
        repeat (2) cycle(4'b0000, 4'b1111, 1'b1, 1'b1, 1'b1);

        // Random segments: chaotic, held with silence, held with releases, junk zz_.
        for (int s = 0; s < 40; s++) begin
            mode = int'($urandom_range(0, 3));
            gh   = 4'($urandom_range(1, 15));
            for (int c = 0; c < 20; c++) begin
                g  = (mode == 0) ? 4'($urandom) : gh;
                z  = '1;
                ok = ($urandom_range(0, 99) >= 4);
                en = ($urandom_range(0, 99) >= 2);
                pe = ($urandom_range(0, 99) >= 2);
                for (int b = 0; b < N; b++) begin
                    if ((mode == 0 || mode == 2) && $urandom_range(0, 99) < 15) z[b] = 1'b0;
                    if (mode == 3) begin
                        if (b != m_rr.own && b != m_fp.own) z[b] = 1'bx;
                        else if ($urandom_range(0, 99) < 10) z[b] = 1'b0;
                    end
                end
                cycle(g, z, ok, en, pe);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
